// File: rtl/victim_cache_pkg.sv
// victim_cache_pkg: shared state encoding, entry tag record and address alignment helper
package victim_cache_pkg;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, RESPOND} vc_state_e;
  typedef struct packed {
    logic        valid;
    logic        dirty;
    logic [31:0] tag;
  } vc_entry_t;
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned s_offset);
    return addr & ~((32'h1 << s_offset) - 32'h1);
  endfunction
endpackage

// File: rtl/victim_cache_param_plru_tree.sv
// plru_tree: heap-ordered tree pseudo-LRU over 2**s_entries slots
module plru_tree #(
  parameter int s_entries = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 touch,
  input  logic [s_entries-1:0] touch_idx,
  output logic [s_entries-1:0] victim_idx
);
  localparam int n = 2 ** s_entries;
  logic [n-2:0] tree, tree_n;
  // follow node bits from the root; a 0 bit sends the walk left
  always_comb begin
    logic [s_entries-1:0] node;
    node = '0;
    victim_idx = '0;
    for (int l = 0; l < s_entries; l++) begin
      victim_idx[s_entries-1-l] = tree[node];
      node = s_entries'(2 * int'(node) + 1 + int'(tree[node]));
    end
  end
  // point every node on the touched path away from the touched slot
  always_comb begin
    logic [s_entries-1:0] node;
    node = '0;
    tree_n = tree;
    for (int l = 0; l < s_entries; l++) begin
      tree_n[node] = ~touch_idx[s_entries-1-l];
      node = s_entries'(2 * int'(node) + 1 + int'(touch_idx[s_entries-1-l]));
    end
  end
  // tree register
  always_ff @(posedge clk) tree <= rst ? '0 : touch ? tree_n : tree;
endmodule

// File: rtl/victim_cache_param.sv
// victim_cache_param: fully-associative victim cache with tree-PLRU and dirty write-back
module victim_cache_param
  import victim_cache_pkg::*;
#(
  parameter int s_entries = 4,
  parameter int width     = 256,
  parameter int s_offset  = $clog2(width / 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [31:0]      req_addr,
  input  logic             evict_valid,
  input  logic [31:0]      evict_addr,
  input  logic             evict_dirty,
  input  logic [width-1:0] evict_data,
  output logic             resp,
  output logic             hit,
  output logic [width-1:0] hit_data,
  output logic             hit_dirty,
  output logic             pmem_write,
  output logic [31:0]      pmem_address,
  output logic [width-1:0] pmem_wdata,
  input  logic             pmem_resp
);
  localparam int n = 2 ** s_entries;
  vc_entry_t            ent  [n];
  logic [width-1:0]     line [n];
  vc_state_e            state, state_n;
  logic [31:0]          r_addr, r_ev_addr;
  logic                 r_ev_valid, r_ev_dirty;
  logic [width-1:0]     r_ev_data;
  logic [s_entries-1:0] hit_idx, dup_idx, free_idx, victim_idx, tgt, wb_tgt, touch_idx;
  logic                 hit_any, dup_any, free_any, need_wb, touch;
  plru_tree #(.s_entries(s_entries)) u_plru (
    .clk       (clk),
    .rst       (rst),
    .touch     (touch),
    .touch_idx (touch_idx),
    .victim_idx(victim_idx)
  );
  // tag search: request hit, evicted-line duplicate, and lowest free slot
  always_comb begin
    hit_any  = 1'b0;
    dup_any  = 1'b0;
    free_any = 1'b0;
    hit_idx  = '0;
    dup_idx  = '0;
    free_idx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (ent[i].valid && ent[i].tag == r_addr) begin
        hit_any = 1'b1;
        hit_idx = s_entries'(i);
      end
      if (ent[i].valid && ent[i].tag == r_ev_addr) begin
        dup_any = 1'b1;
        dup_idx = s_entries'(i);
      end
      if (!ent[i].valid) begin
        free_any = 1'b1;
        free_idx = s_entries'(i);
      end
    end
  end
  // slot selection; installs and PLRU touches always coincide
  always_comb begin
    tgt       = hit_any ? hit_idx : dup_any ? dup_idx : free_any ? free_idx : victim_idx;
    need_wb   = !hit_any && r_ev_valid && !dup_any && !free_any && ent[victim_idx].dirty;
    touch     = (state == COMPARE && r_ev_valid && !need_wb) || (state == WRITEBACK && pmem_resp);
    touch_idx = state == WRITEBACK ? wb_tgt : tgt;
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state and handshake outputs
  always_comb begin
    state_n    = state == IDLE      ? (req ? COMPARE : IDLE) :
                 state == COMPARE   ? (need_wb ? WRITEBACK : RESPOND) :
                 state == WRITEBACK ? (pmem_resp ? RESPOND : WRITEBACK) : IDLE;
    resp       = state == RESPOND;
    pmem_write = state == WRITEBACK;
  end
  // request capture, entry storage, hit result and write-back registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < n; i++) ent[i] <= '0;
      hit          <= 1'b0;
      hit_data     <= '0;
      hit_dirty    <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      if (state == IDLE && req) begin
        r_addr     <= line_align(req_addr, s_offset);
        r_ev_addr  <= line_align(evict_addr, s_offset);
        r_ev_valid <= evict_valid;
        r_ev_dirty <= evict_dirty;
        r_ev_data  <= evict_data;
      end
      if (state == COMPARE) begin
        hit       <= hit_any;
        hit_data  <= hit_any ? line[hit_idx] : '0;
        hit_dirty <= hit_any && ent[hit_idx].dirty;
        wb_tgt    <= tgt;
        if (hit_any) ent[hit_idx].valid <= 1'b0;
        if (need_wb) begin
          pmem_address <= ent[tgt].tag;
          pmem_wdata   <= line[tgt];
        end
      end
      if (touch) begin
        ent[touch_idx]  <= '{valid: 1'b1, dirty: r_ev_dirty, tag: r_ev_addr};
        line[touch_idx] <= r_ev_data;
      end
    end
  end
endmodule
